// File: rtl/tx_nibble_link_pkg.sv
// Shared definitions for the 4-bit parallel FPGA/ESP link, used by both the
// transmitter and the link receiver.
package tx_nibble_link_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int NUM_NIBBLES = 3;
    localparam int WORD_W      = 12;
    localparam int PHASE_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } linkState_e;

    function automatic logic [NIBBLE_W-1:0] selectNibble(
        input logic [WORD_W-1:0]  word,
        input logic [PHASE_W-1:0] phase
    );
        case (phase)
            2'd1:    selectNibble = word[2*NIBBLE_W-1:NIBBLE_W];
            2'd2:    selectNibble = word[3*NIBBLE_W-1:2*NIBBLE_W];
            default: selectNibble = word[NIBBLE_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/tx_nibble_timer.sv
// Loadable down-counter pacing each link state; the zero flag marks the last
// cycle of the current state.
module tx_nibble_timer
    import tx_nibble_link_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_loadValue,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/tx_nibble_link.sv
// Transmit end of the nibble link: sends a 12-bit word as three tagged nibbles,
// each framed by setup, strobe and hold intervals.
module tx_nibble_link
    import tx_nibble_link_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int STB_CYC   = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                ExtClk,
    input  logic                ExtReset,
    input  logic                TxEnable,
    input  logic [WORD_W-1:0]   WordIn,
    input  logic                WordInValid,
    output logic                WordInReady,
    output logic [NIBBLE_W-1:0] LinkData,
    output logic [PHASE_W-1:0]  LinkPhase,
    output logic                LinkPulse,
    output logic                Busy,
    output logic                WordDone
);

    localparam int MAX_SB  = (SETUP_CYC > STB_CYC) ? SETUP_CYC : STB_CYC;
    localparam int MAX_CYC = (MAX_SB > HOLD_CYC) ? MAX_SB : HOLD_CYC;
    localparam int TIMER_W = $clog2(MAX_CYC + 1);

    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] STB_LOAD   = TIMER_W'(STB_CYC - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_NIBBLES - 1);

    if (SETUP_CYC < 1 || STB_CYC < 1 || HOLD_CYC < 1) begin : g_paramCheck
        $error("tx_nibble_link: SETUP_CYC, STB_CYC and HOLD_CYC must all be >= 1");
    end

    linkState_e          r_state;
    logic [WORD_W-1:0]   r_word;
    logic [NIBBLE_W-1:0] r_linkData;
    logic [PHASE_W-1:0]  r_linkPhase;
    logic                r_linkPulse;
    logic                r_busy;
    logic                r_wordDone;

    linkState_e          w_nextState;
    logic [WORD_W-1:0]   w_nextWord;
    logic [NIBBLE_W-1:0] w_nextData;
    logic [PHASE_W-1:0]  w_nextPhase;
    logic                w_nextPulse;
    logic                w_nextBusy;
    logic                w_nextDone;
    logic                w_timerLoad;
    logic [TIMER_W-1:0]  w_timerLoadValue;
    logic                w_timerZero;
    logic                w_accept;
    logic                w_wordInReady;

    assign w_wordInReady = (r_state == IDLE) && TxEnable && !ExtReset;
    assign w_accept      = w_wordInReady && WordInValid;

    tx_nibble_timer #(
        .W(TIMER_W)
    ) u_timer (
        .i_clk      (ExtClk),
        .i_reset    (ExtReset),
        .i_load     (w_timerLoad),
        .i_loadValue(w_timerLoadValue),
        .o_zero     (w_timerZero)
    );

    always_ff @(posedge ExtClk) begin
        if (ExtReset) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_linkData  <= '0;
            r_linkPhase <= '0;
            r_linkPulse <= 1'b0;
            r_busy      <= 1'b0;
            r_wordDone  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_word      <= w_nextWord;
            r_linkData  <= w_nextData;
            r_linkPhase <= w_nextPhase;
            r_linkPulse <= w_nextPulse;
            r_busy      <= w_nextBusy;
            r_wordDone  <= w_nextDone;
        end
    end

    // The timer is reloaded on every state change so it always counts the new state's length.
    always_comb begin
        w_nextState      = r_state;
        w_nextWord       = r_word;
        w_nextData       = r_linkData;
        w_nextPhase      = r_linkPhase;
        w_nextPulse      = 1'b0;
        w_nextBusy       = r_busy;
        w_nextDone       = 1'b0;
        w_timerLoad      = 1'b0;
        w_timerLoadValue = '0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextWord       = WordIn;
                    w_nextData       = selectNibble(WordIn, '0);
                    w_nextPhase      = '0;
                    w_nextBusy       = 1'b1;
                    w_nextState      = SETUP;
                    w_timerLoad      = 1'b1;
                    w_timerLoadValue = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (w_timerZero) begin
                    w_nextState      = STROBE;
                    w_nextPulse      = 1'b1;
                    w_timerLoad      = 1'b1;
                    w_timerLoadValue = STB_LOAD;
                end
            end
            STROBE: begin
                w_nextPulse = 1'b1;
                if (w_timerZero) begin
                    w_nextState      = HOLD;
                    w_nextPulse      = 1'b0;
                    w_timerLoad      = 1'b1;
                    w_timerLoadValue = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (w_timerZero) begin
                    if (r_linkPhase == LAST_PHASE) begin
                        w_nextState = IDLE;
                        w_nextBusy  = 1'b0;
                        w_nextDone  = 1'b1;
                    end else begin
                        w_nextPhase      = r_linkPhase + PHASE_W'(1);
                        w_nextData       = selectNibble(r_word, r_linkPhase + PHASE_W'(1));
                        w_nextState      = SETUP;
                        w_timerLoad      = 1'b1;
                        w_timerLoadValue = SETUP_LOAD;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign WordInReady = w_wordInReady;
    assign LinkData    = r_linkData;
    assign LinkPhase   = r_linkPhase;
    assign LinkPulse   = r_linkPulse;
    assign Busy        = r_busy;
    assign WordDone    = r_wordDone;

endmodule

// File: tb/tb_tx_nibble_link.sv
// Randomized self-checking bench for tx_nibble_link: a timeline reference model
// plus a loopback receiver, with a second fast-timing instance.
module tb_tx_nibble_link;

    localparam int S        = 2;
    localparam int B        = 2;
    localparam int H        = 1;
    localparam int P        = S + B + H;
    localparam int WORD_CYC = 3 * P;
    localparam int FAST_WORD_CYC = 9;

    logic        ExtClk      = 1'b0;
    logic        ExtReset    = 1'b0;
    logic        TxEnable    = 1'b0;
    logic        WordInValid = 1'b0;
    logic [11:0] WordIn      = '0;

    logic        WordInReady, LinkPulse, Busy, WordDone;
    logic [3:0]  LinkData;
    logic [1:0]  LinkPhase;
    logic        fastReady, fastPulse, fastBusy, fastDone;
    logic [3:0]  fastData;
    logic [1:0]  fastPhase;

    tx_nibble_link dut (
        .ExtClk     (ExtClk),
        .ExtReset   (ExtReset),
        .TxEnable   (TxEnable),
        .WordIn     (WordIn),
        .WordInValid(WordInValid),
        .WordInReady(WordInReady),
        .LinkData   (LinkData),
        .LinkPhase  (LinkPhase),
        .LinkPulse  (LinkPulse),
        .Busy       (Busy),
        .WordDone   (WordDone)
    );

    tx_nibble_link #(.SETUP_CYC(1), .STB_CYC(1), .HOLD_CYC(1)) dutFast (
        .ExtClk     (ExtClk),
        .ExtReset   (ExtReset),
        .TxEnable   (TxEnable),
        .WordIn     (WordIn),
        .WordInValid(WordInValid),
        .WordInReady(fastReady),
        .LinkData   (fastData),
        .LinkPhase  (fastPhase),
        .LinkPulse  (fastPulse),
        .Busy       (fastBusy),
        .WordDone   (fastDone)
    );

    always #5 ExtClk = ~ExtClk;

    int testCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic vld, input logic [11:0] w);
        @(posedge ExtClk);
        #1;
        ExtReset    = rst;
        TxEnable    = en;
        WordInValid = vld;
        WordIn      = w;
    endtask

    // Reference model state: position in the word timeline, counted in cycles since accept.
    int          cycle = 0;
    bit          modelActive = 0;
    int          mK = -1;
    logic [11:0] mWord = '0;
    logic [3:0]  mData = '0;
    logic [1:0]  mPhase = '0;
    bit          mDone = 0;
    bit          expPulse, expBusy, expReady;
    int          nibIdx, offs;
    bit          prevAccept = 0, prevReset = 0;
    logic [11:0] prevWordIn = '0;
    int          acceptCount = 0;

    int          dutAcceptEdge = -100, dutDoneEdge = -100;
    bit          dutPrevAccept = 0;

    logic [11:0] expQ[$];
    logic [3:0]  rxNib[3];
    logic [2:0]  rxGot = '0;
    bit          prevPulse = 0;
    logic [11:0] lastRxWord = '0;

    logic [11:0] fastQ[$];
    logic [3:0]  fastNib[3];
    bit          fastPrevAccept = 0, fastPrevPulse = 0;
    int          fastAcceptEdge = -100, fastDoneEdge = -100;
    int          fastPulseCount = 0, fastDoneCount = 0;

    always @(posedge ExtClk) cycle++;

    always @(negedge ExtClk) begin
        if (modelActive) begin
            mDone = 0;
            if (prevReset) begin
                mK = -1; mData = '0; mPhase = '0;
                expQ.delete(); fastQ.delete(); rxGot = '0;
                dutAcceptEdge = -100; dutDoneEdge = -100;
                fastAcceptEdge = -100; fastDoneEdge = -100;
            end else if (prevAccept) begin
                mK = 0; mWord = prevWordIn;
                expQ.push_back(prevWordIn);
                acceptCount++;
            end else if (mK >= 0) begin
                mK++;
                if (mK == WORD_CYC) begin
                    mK = -1; mDone = 1;
                end
            end

            expPulse = 0; expBusy = 0;
            if (mK >= 0) begin
                nibIdx   = mK / P;
                offs     = mK % P;
                mData    = 4'(mWord >> (4 * nibIdx));
                mPhase   = 2'(nibIdx);
                expPulse = (offs >= S) && (offs < S + B);
                expBusy  = 1;
            end
            checkOutput("link_outputs", {LinkData, LinkPhase, LinkPulse, Busy, WordDone},
                        {mData, mPhase, expPulse, expBusy, mDone});

            // Timing measured from the DUT's own handshake and done pulses.
            if (dutPrevAccept) begin
                if (dutDoneEdge == cycle - 1) checkOutput("b2b_gap", cycle - dutAcceptEdge, WORD_CYC + 1);
                dutAcceptEdge = cycle;
            end
            if (WordDone) begin
                checkOutput("done_latency", cycle - dutAcceptEdge, WORD_CYC);
                dutDoneEdge = cycle;
            end

            // Loopback receiver: capture each nibble on the strobe rising edge.
            if (LinkPulse && !prevPulse) begin
                checkOutput("phase_valid", LinkPhase == 2'd3, 0);
                if (LinkPhase != 2'd3) begin
                    if (LinkPhase == 2'd0) rxGot = '0;
                    rxGot[LinkPhase] = 1'b1;
                    rxNib[LinkPhase] = LinkData;
                    if (LinkPhase == 2'd2) begin
                        checkOutput("rx_complete", rxGot, 3'b111);
                        lastRxWord = {rxNib[2], rxNib[1], rxNib[0]};
                        if (expQ.size() > 0) checkOutput("rx_word", lastRxWord, expQ.pop_front());
                        else checkOutput("rx_unexpected", 1, 0);
                    end
                end
            end
            prevPulse = LinkPulse;

            expReady = (mK < 0) && TxEnable && !ExtReset;
            checkOutput("ready", WordInReady, expReady);
            prevAccept    = expReady && WordInValid;
            dutPrevAccept = WordInReady && WordInValid;

            // Fast instance: 1-cycle intervals, 9-cycle word.
            if (fastPrevAccept) begin
                if (fastDoneEdge == cycle - 1) checkOutput("fast_gap", cycle - fastAcceptEdge, FAST_WORD_CYC + 1);
                fastAcceptEdge = cycle;
                fastPulseCount = 0;
            end
            if (fastPulse) begin
                checkOutput("fast_pulse_width", fastPrevPulse, 0);
                checkOutput("fast_phase_valid", fastPhase == 2'd3, 0);
                fastPulseCount++;
                if (fastPhase != 2'd3) fastNib[fastPhase] = fastData;
                if (fastPhase == 2'd2) begin
                    if (fastQ.size() > 0) checkOutput("fast_rx_word", {fastNib[2], fastNib[1], fastNib[0]}, fastQ.pop_front());
                    else checkOutput("fast_rx_unexpected", 1, 0);
                end
            end
            if (fastDone) begin
                checkOutput("fast_done_latency", cycle - fastAcceptEdge, FAST_WORD_CYC);
                checkOutput("fast_pulse_count", fastPulseCount, 3);
                fastDoneEdge = cycle;
                fastDoneCount++;
            end
            fastPrevPulse  = fastPulse;
            fastPrevAccept = fastReady && WordInValid;
            if (fastPrevAccept) fastQ.push_back(WordIn);
        end
        prevReset  = ExtReset;
        prevWordIn = WordIn;
        if (!modelActive && ExtReset) modelActive = 1;
    end

    initial begin
        int  base;
        int  fastBase;
        bit  found;

        repeat (3) applyStimulus(1, 0, 0, 12'h000);
        applyStimulus(0, 1, 0, 12'h000);
        @(negedge ExtClk);
        checkOutput("reset_state", {LinkData, LinkPhase, LinkPulse, Busy, WordDone}, 0);

        // Single word 0xA5C.
        applyStimulus(0, 1, 1, 12'hA5C);
        applyStimulus(0, 1, 0, 12'h000);
        repeat (20) applyStimulus(0, 1, 0, 12'h000);
        checkOutput("a5c_rx", lastRxWord, 12'hA5C);

        // Back-to-back words with WordInValid held.
        base = acceptCount;
        applyStimulus(0, 1, 1, 12'h123);
        applyStimulus(0, 1, 1, 12'hFED);
        for (int k = 0; k < 40 && acceptCount - base < 2; k++) applyStimulus(0, 1, 1, 12'hFED);
        applyStimulus(0, 1, 0, 12'h000);
        checkOutput("b2b_accepts", acceptCount - base, 2);
        repeat (20) applyStimulus(0, 1, 0, 12'h000);
        checkOutput("b2b_rx", lastRxWord, 12'hFED);

        // Reset during the phase-1 strobe.
        applyStimulus(0, 1, 1, 12'h9B7);
        applyStimulus(0, 1, 0, 12'h000);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge ExtClk);
            if (LinkPulse && LinkPhase == 2'd1) found = 1;
        end
        checkOutput("strobe_phase1_seen", found, 1);
        applyStimulus(1, 1, 0, 12'h000);
        applyStimulus(0, 1, 0, 12'h000);
        @(negedge ExtClk);
        checkOutput("reset_midword", {LinkData, LinkPhase, LinkPulse, Busy, WordDone}, 0);
        repeat (20) applyStimulus(0, 1, 0, 12'h000);
        applyStimulus(0, 1, 1, 12'h3C4);
        applyStimulus(0, 1, 0, 12'h000);
        repeat (20) applyStimulus(0, 1, 0, 12'h000);
        checkOutput("post_reset_rx", lastRxWord, 12'h3C4);

        // TxEnable gating.
        repeat (10) applyStimulus(0, 0, 1, 12'h555);
        @(negedge ExtClk);
        checkOutput("disabled_ready", WordInReady, 0);
        checkOutput("disabled_busy", Busy, 0);
        base = acceptCount;
        applyStimulus(0, 1, 1, 12'h6A9);
        repeat (30) applyStimulus(0, 0, 1, 12'h111);
        checkOutput("enable_drop_accepts", acceptCount - base, 1);
        checkOutput("enable_drop_rx", lastRxWord, 12'h6A9);

        // Fast-timing instance with continuous traffic.
        repeat (2) applyStimulus(1, 0, 0, 12'h000);
        fastBase = fastDoneCount;
        for (int k = 0; k < 40; k++) applyStimulus(0, 1, 1, 12'($urandom));
        applyStimulus(0, 1, 0, 12'h000);
        repeat (20) applyStimulus(0, 1, 0, 12'h000);
        checkOutput("fast_words_done", (fastDoneCount - fastBase) >= 3, 1);
        checkOutput("fast_idle", fastBusy, 0);

        // Randomized traffic: 100 words through the loopback receiver.
        base = acceptCount;
        for (int k = 0; k < 4000 && acceptCount - base < 100; k++)
            applyStimulus(0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 12'($urandom));
        applyStimulus(0, 1, 0, 12'h000);
        repeat (25) applyStimulus(0, 1, 0, 12'h000);
        checkOutput("random_accepts", (acceptCount - base) >= 100, 1);
        checkOutput("rx_queue_drained", expQ.size(), 0);
        checkOutput("fast_queue_drained", fastQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
